// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_HALT_REQ   = 2'b01,
        CAUSE_BREAKPOINT = 2'b10,
        CAUSE_STEP       = 2'b11
    } halt_cause_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_dbg_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_dbg_ctrl : run/halt FSM, breakpoint compare and halt-cause tracking
// Revision       : 1.0
// ============================================================================
module fetch_dbg_ctrl
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] pc,
    input  logic        halt_req,
    input  logic        resume_req,
    input  logic        step,
    input  logic        pc_wr,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        issue_en,
    output logic        hold_pc,
    output logic        load_dbg_pc,
    output logic        halted,
    output logic [1:0]  cause
);

    fetch_state_e state, state_next;
    halt_cause_e  cause_q, cause_next;
    logic         skip_bp, skip_bp_next;
    logic         step_pend, step_pend_next;
    logic         bp_match;

    // skip_bp lets the instruction at a breakpoint issue once after resume
    assign bp_match = (state == RUN) && bp_en && (pc == bp_addr) && !skip_bp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cause_q   <= CAUSE_NONE;
            skip_bp   <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            state     <= state_next;
            cause_q   <= cause_next;
            skip_bp   <= skip_bp_next;
            step_pend <= step_pend_next;
        end
    end

    always_comb begin
        state_next     = state;
        cause_next     = cause_q;
        skip_bp_next   = skip_bp;
        step_pend_next = step_pend;
        issue_en       = 1'b0;
        load_dbg_pc    = 1'b0;
        if (!stall) begin
            unique case (state)
                RUN: begin
                    if (bp_match) begin
                        state_next = HALTED;
                        cause_next = CAUSE_BREAKPOINT;
                    end else if (halt_req) begin
                        state_next = HALTED;
                        cause_next = CAUSE_HALT_REQ;
                    end else if (!redirect) begin
                        issue_en     = 1'b1;
                        skip_bp_next = 1'b0;
                        if (step_pend) begin
                            state_next     = HALTED;
                            cause_next     = CAUSE_STEP;
                            step_pend_next = 1'b0;
                        end
                    end
                end
                HALTED: begin
                    load_dbg_pc = pc_wr && !redirect;
                    if (resume_req && !halt_req) begin
                        state_next     = RUN;
                        cause_next     = CAUSE_NONE;
                        skip_bp_next   = 1'b1;
                        step_pend_next = step;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign hold_pc = !issue_en && !load_dbg_pc;
    assign halted  = (state == HALTED);
    assign cause   = cause_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : RV32I fetch stage - PC register, IF/ID register, debug hooks
// Revision    : 1.0
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        dbg_halt_req_i,
    input  logic        dbg_resume_req_i,
    input  logic        dbg_step_i,
    input  logic        dbg_pc_wr_i,
    input  logic [31:0] dbg_pc_wdata_i,
    input  logic        bp_en_i,
    input  logic [31:0] bp_addr_i,
    output logic        dbg_halted_o,
    output logic [1:0]  dbg_cause_o
);

    logic issue_en;
    logic hold_pc;
    logic load_dbg_pc;

    fetch_dbg_ctrl u_dbg_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall_i),
        .redirect    (redirect_valid_i),
        .pc          (pc_o),
        .halt_req    (dbg_halt_req_i),
        .resume_req  (dbg_resume_req_i),
        .step        (dbg_step_i),
        .pc_wr       (dbg_pc_wr_i),
        .bp_en       (bp_en_i),
        .bp_addr     (bp_addr_i),
        .issue_en    (issue_en),
        .hold_pc     (hold_pc),
        .load_dbg_pc (load_dbg_pc),
        .halted      (dbg_halted_o),
        .cause       (dbg_cause_o)
    );

    // Redirect wins even under stall; the controller already folds stall into issue/load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_o       <= word_align(RESET_PC);
            if_valid_o <= 1'b0;
            if_pc_o    <= 32'h0000_0000;
            if_instr_o <= NOP_INSTR;
        end else if (redirect_valid_i) begin
            pc_o       <= word_align(redirect_pc_i);
            if_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if_valid_o <= issue_en;
            if (issue_en) begin
                if_pc_o    <= pc_o;
                if_instr_o <= instr_i;
            end
            if (!hold_pc) begin
                pc_o <= load_dbg_pc ? word_align(dbg_pc_wdata_i) : pc_o + PC_STEP;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Self-checking bench for fetch_stage: directed vector table, hand-written
// wrap/reset sequences, then randomized traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        dbg_halt_req_i;
    logic        dbg_resume_req_i;
    logic        dbg_step_i;
    logic        dbg_pc_wr_i;
    logic [31:0] dbg_pc_wdata_i;
    logic        bp_en_i;
    logic [31:0] bp_addr_i;
    logic        dbg_halted_o;
    logic [1:0]  dbg_cause_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    assign instr_i = imem(pc_o);

    fetch_stage #(.RESET_PC(32'h0000_0008)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_o             (pc_o),
        .instr_i          (instr_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_instr_o       (if_instr_o),
        .dbg_halt_req_i   (dbg_halt_req_i),
        .dbg_resume_req_i (dbg_resume_req_i),
        .dbg_step_i       (dbg_step_i),
        .dbg_pc_wr_i      (dbg_pc_wr_i),
        .dbg_pc_wdata_i   (dbg_pc_wdata_i),
        .bp_en_i          (bp_en_i),
        .bp_addr_i        (bp_addr_i),
        .dbg_halted_o     (dbg_halted_o),
        .dbg_cause_o      (dbg_cause_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic [31:0] e_ifpc, input logic [31:0] e_instr,
                             input logic e_halted, input logic [1:0] e_cause);
        check({tag, ".pc"},     pc_o,         e_pc);
        check({tag, ".valid"},  if_valid_o,   e_valid);
        check({tag, ".ifpc"},   if_pc_o,      e_ifpc);
        check({tag, ".instr"},  if_instr_o,   e_instr);
        check({tag, ".halted"}, dbg_halted_o, e_halted);
        check({tag, ".cause"},  dbg_cause_o,  e_cause);
    endtask

    task automatic idle_inputs();
        stall_i = 0; redirect_valid_i = 0; redirect_pc_i = 0;
        dbg_halt_req_i = 0; dbg_resume_req_i = 0; dbg_step_i = 0;
        dbg_pc_wr_i = 0; dbg_pc_wdata_i = 0; bp_en_i = 0; bp_addr_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] redir_pc;
        logic        halt;
        logic        resume;
        logic        step;
        logic        pcwr;
        logic [31:0] pcw;
        logic        bpen;
        logic [31:0] bpa;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_ifpc;
        logic        e_halted;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rdpc,
                               input logic hr, input logic rs, input logic sp,
                               input logic pw, input logic [31:0] pwd,
                               input logic be, input logic [31:0] ba,
                               input logic [31:0] epc, input logic ev, input logic [31:0] eifpc,
                               input logic eh, input logic [1:0] ec);
        vec_t r;
        r = '{stall: st, redir: rd, redir_pc: rdpc, halt: hr, resume: rs, step: sp,
              pcwr: pw, pcw: pwd, bpen: be, bpa: ba,
              e_pc: epc, e_valid: ev, e_ifpc: eifpc, e_halted: eh, e_cause: ec};
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_ipc, m_instr;
    logic        m_valid, m_halted, m_skip, m_step;
    logic [1:0]  m_cause;

    task automatic model_reset();
        m_pc = 32'h8; m_valid = 0; m_ipc = 0; m_instr = 32'h0000_0013;
        m_halted = 0; m_cause = 0; m_skip = 0; m_step = 0;
    endtask

    task automatic model_step();
        logic [1:0] why;
        if (!m_halted) begin
            if (!stall_i) begin
                why = 2'd0;
                if (bp_en_i && m_pc == bp_addr_i && !m_skip) why = 2'd2;
                else if (dbg_halt_req_i)                      why = 2'd1;
                if (why != 2'd0) begin
                    m_halted = 1; m_cause = why; m_valid = 0;
                end else if (!redirect_valid_i) begin
                    m_valid = 1; m_ipc = m_pc; m_instr = imem(m_pc);
                    m_pc = m_pc + 32'd4; m_skip = 0;
                    if (m_step) begin
                        m_halted = 1; m_cause = 2'd3; m_step = 0;
                    end
                end
            end
        end else if (!stall_i) begin
            m_valid = 0;
            if (dbg_pc_wr_i) m_pc = dbg_pc_wdata_i & ~32'h3;
            if (dbg_resume_req_i && !dbg_halt_req_i) begin
                m_halted = 0; m_skip = 1; m_step = dbg_step_i; m_cause = 0;
            end
        end
        if (redirect_valid_i) begin
            m_pc = redirect_pc_i & ~32'h3;
            m_valid = 0;
        end
    endtask

    initial begin
        //                st rd rdpc      hr rs sp pw pwd       be ba        e_pc       ev e_ifpc     eh ec
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        32'h0C,    1, 32'h08,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        32'h10,    1, 32'h0C,    0, 0));
        vecs.push_back(v(0, 1, 32'h0B,   0, 0, 0, 0, 0,        0, 0,        32'h08,    0, 32'h0C,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        32'h0C,    1, 32'h08,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        32'h10,    1, 32'h0C,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h14,    1, 32'h10,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h18,    1, 32'h14,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h1C,    1, 32'h18,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h20,    1, 32'h1C,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h24,    1, 32'h20,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h24,    0, 32'h20,    1, 2));
        vecs.push_back(v(0, 0, 0,        0, 1, 0, 0, 0,        1, 32'h24,   32'h24,    0, 32'h20,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h28,    1, 32'h24,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h2C,    1, 32'h28,    0, 0));
        vecs.push_back(v(0, 1, 32'h24,   0, 0, 0, 0, 0,        1, 32'h24,   32'h24,    0, 32'h28,    0, 0));
        vecs.push_back(v(0, 0, 0,        1, 0, 0, 0, 0,        1, 32'h24,   32'h24,    0, 32'h28,    1, 2));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 1, 32'h33,   1, 32'h24,   32'h30,    0, 32'h28,    1, 2));
        vecs.push_back(v(0, 0, 0,        0, 1, 1, 0, 0,        1, 32'h24,   32'h30,    0, 32'h28,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        1, 32'h24,   32'h34,    1, 32'h30,    1, 3));
        vecs.push_back(v(0, 0, 0,        0, 1, 0, 0, 0,        0, 0,        32'h34,    0, 32'h30,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        32'h38,    1, 32'h34,    0, 0));
        vecs.push_back(v(1, 0, 0,        1, 0, 0, 0, 0,        0, 0,        32'h38,    1, 32'h34,    0, 0));
        vecs.push_back(v(1, 0, 0,        1, 0, 0, 0, 0,        0, 0,        32'h38,    1, 32'h34,    0, 0));
        vecs.push_back(v(1, 0, 0,        1, 0, 0, 0, 0,        0, 0,        32'h38,    1, 32'h34,    0, 0));
        vecs.push_back(v(0, 0, 0,        1, 0, 0, 0, 0,        0, 0,        32'h38,    0, 32'h34,    1, 1));
        vecs.push_back(v(1, 1, 32'h100,  0, 0, 0, 0, 0,        0, 0,        32'h100,   0, 32'h34,    1, 1));
        vecs.push_back(v(0, 0, 0,        0, 1, 0, 0, 0,        0, 0,        32'h100,   0, 32'h34,    0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        32'h104,   1, 32'h100,   0, 0));
        vecs.push_back(v(0, 0, 0,        1, 0, 0, 0, 0,        0, 0,        32'h104,   0, 32'h100,   1, 1));
        vecs.push_back(v(0, 0, 0,        1, 1, 0, 0, 0,        0, 0,        32'h104,   0, 32'h100,   1, 1));
        vecs.push_back(v(0, 0, 0,        0, 1, 0, 0, 0,        0, 0,        32'h104,   0, 32'h100,   0, 0));
        vecs.push_back(v(0, 0, 0,        0, 0, 0, 0, 0,        0, 0,        32'h108,   1, 32'h104,   0, 0));

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset", 32'h8, 0, 32'h0, 32'h0000_0013, 0, 0);

        foreach (vecs[i]) begin
            stall_i          = vecs[i].stall;
            redirect_valid_i = vecs[i].redir;
            redirect_pc_i    = vecs[i].redir_pc;
            dbg_halt_req_i   = vecs[i].halt;
            dbg_resume_req_i = vecs[i].resume;
            dbg_step_i       = vecs[i].step;
            dbg_pc_wr_i      = vecs[i].pcwr;
            dbg_pc_wdata_i   = vecs[i].pcw;
            bp_en_i          = vecs[i].bpen;
            bp_addr_i        = vecs[i].bpa;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_ifpc,
                      imem(vecs[i].e_ifpc), vecs[i].e_halted, vecs[i].e_cause);
        end

        // PC wrap at the top of the address space
        idle_inputs();
        redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        check("wrap.redir_pc", pc_o, 32'hFFFF_FFFC);
        redirect_valid_i = 0;
        tick();
        check_all("wrap", 32'h0, 1, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC), 0, 0);

        // Asynchronous reset while a single-step is pending
        dbg_halt_req_i = 1;
        tick();
        check("step.halted", dbg_halted_o, 1);
        dbg_halt_req_i = 0; dbg_resume_req_i = 1; dbg_step_i = 1;
        tick();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h8, 0, 32'h0, 32'h0000_0013, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("post_rst1", 32'hC, 1, 32'h8, imem(32'h8), 0, 0);
        tick();
        check_all("post_rst2", 32'h10, 1, 32'hC, imem(32'hC), 0, 0);

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000 && n_bad < 20; c++) begin
            stall_i          = ($urandom_range(0, 99) < 20);
            redirect_valid_i = ($urandom_range(0, 99) < 8);
            redirect_pc_i    = ($urandom_range(0, 99) < 5) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                          : ($urandom & 32'h0000_00FF);
            dbg_halt_req_i   = ($urandom_range(0, 99) < 10);
            dbg_resume_req_i = ($urandom_range(0, 99) < 30);
            dbg_step_i       = ($urandom_range(0, 99) < 50);
            dbg_pc_wr_i      = ($urandom_range(0, 99) < 10);
            dbg_pc_wdata_i   = $urandom & 32'h0000_00FF;
            bp_en_i          = ($urandom_range(0, 99) < 50);
            case ($urandom_range(0, 2))
                0:       bp_addr_i = m_pc;
                1:       bp_addr_i = m_pc + 32'd4;
                default: bp_addr_i = $urandom & 32'h0000_00FC;
            endcase
            model_step();
            tick();
            check_all($sformatf("rnd%0d", c), m_pc, m_valid, m_ipc, m_instr, m_halted, m_cause);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue RV32I core, directly upstream of the combinational instruction memory. Holds the program counter, drives the memory address, and captures the returned word into the IF/ID pipeline register. Applies branch/jump redirects from execute and implements the fetch-side halt/resume/single-step and hardware-breakpoint hooks used by the external debugger.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low (one clock, async active-low reset, as fixed for this block).
- pc_o  out  32  fetch address to instruction memory; always word-aligned.
- instr_i  in  32  instruction word for pc_o, valid in the same cycle (memory is combinational).
- stall_i  in  1  downstream cannot accept; freezes PC, IF/ID register and FSM.
- redirect_valid_i  in  1  taken branch/jump from execute.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and forced to 0.
- if_valid_o  out  1  IF/ID entry valid.
- if_pc_o  out  32  PC of IF/ID entry.
- if_instr_o  out  32  instruction of IF/ID entry.
- dbg_halt_req_i  in  1  debugger halt request (level).
- dbg_resume_req_i  in  1  resume pulse, honoured only in HALTED.
- dbg_step_i  in  1  qualifies resume as single-step.
- dbg_pc_wr_i  in  1  write PC, honoured only in HALTED.
- dbg_pc_wdata_i  in  32  new PC; bits [1:0] forced to 0.
- bp_en_i  in  1  breakpoint enable.
- bp_addr_i  in  32  breakpoint address.
- dbg_halted_o  out  1  core is halted.
- dbg_cause_o  out  2  halt cause: 00 none, 01 halt request, 10 breakpoint, 11 step.

## Operation
- States: RUN, HALTED. Internal flags: skip_bp (one-shot breakpoint bypass), step_pend.
- "Issue" in RUN with stall_i=0: IF/ID <= {1, pc_o, instr_i}; PC <= PC+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
- Per-edge priority: reset > redirect > stall > halt/breakpoint > issue.
- Redirect (any state, even with stall_i=1): PC <= redirect_pc_i & ~3; if_valid_o <= 0; no issue that cycle; state unaffected except as below.
- stall_i=1 without redirect: PC, IF/ID, state, flags all hold; debug inputs ignored.
- RUN, no stall: breakpoint match = bp_en_i && pc_o==bp_addr_i && !skip_bp. Match -> HALTED, cause 10, no issue, PC held. Else dbg_halt_req_i -> HALTED, cause 01, no issue. Else issue; issue clears skip_bp; if step_pend, go HALTED, cause 11, clear step_pend.
- Breakpoint and halt request together: cause 10.
- Redirect coinciding with halt/breakpoint: redirect applied and state -> HALTED; halted PC is the redirect target.
- HALTED: if_valid_o <= 0, PC held. dbg_pc_wr_i loads PC (redirect wins if simultaneous). dbg_resume_req_i with dbg_halt_req_i=0 -> RUN, skip_bp <= 1, step_pend <= dbg_step_i, cause <= 00. Resume while halt request still high is ignored.
- Reset values: pc_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=32'h0000_0013 (NOP), dbg_halted_o=0, dbg_cause_o=00, state RUN, flags 0.
- Reset mid-operation clears everything asynchronously, including a pending step.

## Timing
- pc_o and all IF/ID outputs are registered; only memory read is combinational.
- Fetch-to-IF/ID latency: 1 cycle. Throughput: 1 instruction/cycle when not stalled.
- Redirect penalty: 1 bubble (if_valid_o=0 for one cycle), target in IF/ID the following edge.
- dbg_halted_o asserts the edge the state enters HALTED; deasserts the edge of resume.
- Single-step: exactly one issue between resume and re-halt (2 edges total).

## Structure
- Package fetch_pkg: fetch_state_e {RUN, HALTED}; halt_cause_e (2-bit codes above); NOP_INSTR = 32'h0000_0013; PC_STEP = 4.
- One sub-module, fetch_dbg_ctrl: FSM, skip_bp/step_pend, breakpoint comparator, cause register; outputs issue_en, hold_pc, load_dbg_pc. Top holds PC and IF/ID registers.

## Test plan
- Reset release, RESET_PC=0x08, stall_i=0 -> pc_o 0x08, 0x0C, 0x10 on successive edges; if_pc_o trails by one cycle with matching instr_i.
- Redirect to 0x0B at pc_o=0x10 -> pc_o=0x08 next edge, one bubble, then if_pc_o=0x08.
- bp_en_i=1, bp_addr_i=0x24 -> halt with pc_o=0x24, cause 10, 0x24 not issued; resume -> 0x24 issued once, no re-halt; PC reaches 0x28.
- Halted at 0x24, dbg_pc_wr_i with 0x30 then resume+step -> one issue at 0x30, halt at pc_o=0x34, cause 11.
- stall_i=1 for 3 cycles with dbg_halt_req_i=1 -> no change; halt taken on first unstalled edge; redirect during stall still updates PC.
- PC at 0xFFFF_FFFC issued -> pc_o wraps to 0x0000_0000; rst_n pulsed mid-step -> all outputs at reset values, state RUN.
